// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: round-robin ALU/LSU write-back arbiter with a register scoreboard gating issue
// Ports: clk/rst (sync active-high); alu_*/lsu_* valid-ready write-back ports (rd, wd);
//        rf_we/rf_rd/rf_wd registered register-file write; iss_valid/iss_rs1/iss_rs2/iss_rd issue query;
//        iss_stall combinational hazard flag; busy_vec scoreboard (bit i = write to xi in flight).
module rf_wb_arbiter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_wd,
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic [4:0]      lsu_rd,
  input  logic [XLEN-1:0] lsu_wd,
  output logic            rf_we,
  output logic [4:0]      rf_rd,
  output logic [XLEN-1:0] rf_wd,
  input  logic            iss_valid,
  input  logic [4:0]      iss_rs1,
  input  logic [4:0]      iss_rs2,
  input  logic [4:0]      iss_rd,
  output logic            iss_stall,
  output logic [31:0]     busy_vec
);
  logic            r_last;
  logic [31:0]     r_busy;
  logic            w_hs;
  logic [4:0]      w_rd;
  logic [XLEN-1:0] w_wd;
  logic [31:0]     w_set;
  logic [31:0]     w_clr;
  // r_last holds the most recently granted port (1 = LSU); reset value 1 lets the ALU win first.
  // r_busy[0] is never set, so x0 indices need no separate masking in the hazard check.
  always_comb begin
    alu_ready = alu_valid && (!lsu_valid || r_last);
    lsu_ready = lsu_valid && (!alu_valid || !r_last);
    w_hs      = alu_ready || lsu_ready;
    w_rd      = alu_ready ? alu_rd : lsu_rd;
    w_wd      = alu_ready ? alu_wd : lsu_wd;
    iss_stall = iss_valid && (r_busy[iss_rs1] || r_busy[iss_rs2] || r_busy[iss_rd]);
    w_set     = (iss_valid && !iss_stall && iss_rd != 5'd0) ? (32'd1 << iss_rd) : 32'd0;
    w_clr     = rf_we ? (32'd1 << rf_rd) : 32'd0;
    busy_vec  = r_busy;
  end
  // Set is OR'd after the clear so a same-register collision resolves to busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last <= 1'b1;
      r_busy <= '0;
      rf_we  <= 1'b0;
      rf_rd  <= '0;
      rf_wd  <= '0;
    end else begin
      if (w_hs) r_last <= lsu_ready;
      r_busy <= ((r_busy & ~w_clr) | w_set) & 32'hFFFF_FFFE;
      rf_we  <= w_hs && w_rd != 5'd0;
      rf_rd  <= w_rd;
      rf_wd  <= w_wd;
    end
  end
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: directed self-checking bench for rf_wb_arbiter
module tb_rf_wb_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, lsu_valid, alu_ready, lsu_ready;
  logic [4:0]  alu_rd, lsu_rd, rf_rd, iss_rs1, iss_rs2, iss_rd;
  logic [31:0] alu_wd, lsu_wd, rf_wd, busy_vec;
  logic        rf_we, iss_valid, iss_stall;
  int          checks = 0;
  int          failures = 0;

  rf_wb_arbiter #(.XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_wd(alu_wd),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_wd(lsu_wd),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wd(rf_wd),
    .iss_valid(iss_valid), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_rd(iss_rd),
    .iss_stall(iss_stall), .busy_vec(busy_vec)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    #0;
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; alu_valid = 0; lsu_valid = 0; alu_rd = 0; lsu_rd = 0; alu_wd = 0; lsu_wd = 0;
    iss_valid = 0; iss_rs1 = 0; iss_rs2 = 0; iss_rd = 0;
    step(); step();
    rst = 1'b0;
    #1;
    chk("rst_busy", busy_vec, 0);
    chk("rst_we", {31'd0, rf_we}, 0);
    chk("rst_rd", {27'd0, rf_rd}, 0);
    chk("rst_wd", rf_wd, 0);
    chk("rst_stall", {31'd0, iss_stall}, 0);
    // single ALU write
    alu_valid = 1; alu_rd = 5; alu_wd = 32'hDEADBEEF;
    #1;
    chk("single_alu_ready", {31'd0, alu_ready}, 1);
    chk("single_lsu_ready", {31'd0, lsu_ready}, 0);
    step();
    alu_valid = 0;
    chk("single_we", {31'd0, rf_we}, 1);
    chk("single_rd", {27'd0, rf_rd}, 5);
    chk("single_wd", rf_wd, 32'hDEADBEEF);
    step();
    chk("single_we_off", {31'd0, rf_we}, 0);
    // contention after reset
    rst = 1; step(); rst = 0;
    alu_valid = 1; lsu_valid = 1; alu_rd = 1; lsu_rd = 2; alu_wd = 32'h11; lsu_wd = 32'h22;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr_alu_ready", {31'd0, alu_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("rr_lsu_ready", {31'd0, lsu_ready}, (i % 2 == 0) ? 32'd0 : 32'd1);
      step();
      chk("rr_we", {31'd0, rf_we}, 1);
      chk("rr_rd", {27'd0, rf_rd}, (i % 2 == 0) ? 32'd1 : 32'd2);
      chk("rr_wd", rf_wd, (i % 2 == 0) ? 32'h11 : 32'h22);
    end
    alu_valid = 0;
    #1;
    chk("lone_lsu_ready", {31'd0, lsu_ready}, 1);
    lsu_valid = 0;
    #1;
    chk("idle_alu_ready", {31'd0, alu_ready}, 0);
    chk("idle_lsu_ready", {31'd0, lsu_ready}, 0);
    step();
    chk("idle_we", {31'd0, rf_we}, 0);
    // RAW on x7
    iss_valid = 1; iss_rd = 7;
    #1;
    chk("raw_issue_stall", {31'd0, iss_stall}, 0);
    step();
    iss_rd = 0; iss_rs1 = 7;
    chk("raw_busy_set", busy_vec, 32'h80);
    chk("raw_stall1", {31'd0, iss_stall}, 1);
    step();
    chk("raw_stall2", {31'd0, iss_stall}, 1);
    lsu_valid = 1; lsu_rd = 7; lsu_wd = 32'h77;
    #1;
    chk("raw_lsu_ready", {31'd0, lsu_ready}, 1);
    step();
    lsu_valid = 0;
    chk("raw_we", {31'd0, rf_we}, 1);
    chk("raw_rd", {27'd0, rf_rd}, 7);
    chk("raw_stall_wecycle", {31'd0, iss_stall}, 1);
    chk("raw_busy_wecycle", busy_vec, 32'h80);
    step();
    chk("raw_busy_clr", busy_vec, 0);
    chk("raw_stall_drop", {31'd0, iss_stall}, 0);
    chk("raw_we_off", {31'd0, rf_we}, 0);
    iss_rs1 = 0; iss_valid = 0;
    // WAW and x0
    iss_valid = 1; iss_rd = 9;
    step();
    chk("waw_busy", busy_vec, 32'h200);
    chk("waw_stall", {31'd0, iss_stall}, 1);
    iss_valid = 0;
    #1;
    chk("noval_stall", {31'd0, iss_stall}, 0);
    iss_valid = 1; iss_rd = 0;
    #1;
    chk("x0_stall", {31'd0, iss_stall}, 0);
    step();
    iss_valid = 0;
    chk("x0_busy", busy_vec, 32'h200);
    lsu_valid = 1; lsu_rd = 0; lsu_wd = 32'h55;
    #1;
    chk("x0_lsu_ready", {31'd0, lsu_ready}, 1);
    step();
    lsu_valid = 0;
    chk("x0_we", {31'd0, rf_we}, 0);
    chk("x0_busy2", busy_vec, 32'h200);
    // clear x9 and set x10 in the same cycle
    alu_valid = 1; alu_rd = 9; alu_wd = 32'h99;
    step();
    alu_valid = 0;
    chk("setclr_we", {31'd0, rf_we}, 1);
    chk("setclr_rd", {27'd0, rf_rd}, 9);
    iss_valid = 1; iss_rd = 10;
    #1;
    chk("setclr_stall", {31'd0, iss_stall}, 0);
    step();
    iss_valid = 0; iss_rd = 0;
    chk("setclr_busy", busy_vec, 32'h400);
    // write-back to a non-busy register
    alu_valid = 1; alu_rd = 12; alu_wd = 32'hC;
    step();
    alu_valid = 0;
    chk("nonbusy_we", {31'd0, rf_we}, 1);
    chk("nonbusy_wd", rf_wd, 32'hC);
    step();
    chk("nonbusy_busy", busy_vec, 32'h400);
    // reset mid-flight
    iss_valid = 1; iss_rd = 3;
    step();
    iss_valid = 0; iss_rd = 0;
    chk("mid_busy3", busy_vec, 32'h408);
    lsu_valid = 1; lsu_rd = 3; lsu_wd = 32'h33;
    step();
    lsu_valid = 0;
    chk("mid_we_before_rst", {31'd0, rf_we}, 1);
    rst = 1; alu_valid = 1; lsu_valid = 1; alu_rd = 1; lsu_rd = 2;
    step();
    chk("mid_rst_we", {31'd0, rf_we}, 0);
    chk("mid_rst_busy", busy_vec, 0);
    chk("mid_rst_alu_ready", {31'd0, alu_ready}, 1);
    step();
    chk("mid_rst_hs_noeffect", {31'd0, rf_we}, 0);
    rst = 0;
    #1;
    chk("post_rst_alu_ready", {31'd0, alu_ready}, 1);
    chk("post_rst_lsu_ready", {31'd0, lsu_ready}, 0);
    chk("post_rst_we", {31'd0, rf_we}, 0);
    step();
    alu_valid = 0; lsu_valid = 0;
    chk("post_rst_grant_rd", {27'd0, rf_rd}, 1);
    chk("post_rst_grant_we", {31'd0, rf_we}, 1);
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 Parameter: XLEN, 32, data width of write-back values.
REQ-002 Port: clk  in  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst  in  1  synchronous, active-high reset.
REQ-004 Port: alu_valid / alu_ready  in / out  1 / 1  port-0 write-back handshake.
REQ-005 Port: alu_rd / alu_wd  in  5 / XLEN  port-0 destination register and data.
REQ-006 Port: lsu_valid / lsu_ready  in / out  1 / 1  port-1 write-back handshake.
REQ-007 Port: lsu_rd / lsu_wd  in  5 / XLEN  port-1 destination register and data.
REQ-008 Port: rf_we / rf_rd / rf_wd  out  1 / 5 / XLEN  registered drive of the register-file write port.
REQ-009 Port: iss_valid  in  1  decode presents an instruction for issue.
REQ-010 Port: iss_rs1, iss_rs2, iss_rd  in  5 each  source and destination indices; value 0 means unused or x0.
REQ-011 Port: iss_stall  out  1  combinational; issue is blocked this cycle.
REQ-012 Port: busy_vec  out  32  scoreboard state; bit i set = write to xi in flight.

Function
REQ-013 Handshake completes on a port when valid && ready are both high at a rising edge; ready is combinational from the valids and the RR pointer, and at most one ready is high per cycle.
REQ-014 One valid: that port's ready is high.
REQ-015 Both valid: ready goes to the port that was not granted most recently (round-robin); after reset, port 0 (ALU) wins first.
REQ-016 RR pointer records the last granted port and updates on every completed handshake, contended or not.
REQ-017 Neither valid: both readys low, pointer holds.
REQ-018 Latency: a handshake at edge N drives rf_we=1, rf_rd=rd and rf_wd=wd for exactly the cycle after edge N; otherwise rf_we=0.
REQ-019 Output contention is impossible, so the arbiter never stalls a granted port.
REQ-020 Handshake with rd=0 completes normally, but the following cycle has rf_we=0 and the scoreboard is unchanged.
REQ-021 Issue: iss_stall=1 iff iss_valid && (busy[iss_rs1] || busy[iss_rs2] || busy[iss_rd]) for nonzero indices (RAW plus WAW).
REQ-022 iss_stall=0 whenever iss_valid=0.
REQ-023 Set: at an edge with iss_valid && !iss_stall && iss_rd!=0, busy[iss_rd] is set.
REQ-024 Clear: at an edge with rf_we=1, busy[rf_rd] is cleared; no same-cycle bypass, so dependants issue at the earliest the cycle after the clear edge.
REQ-025 Set and clear of different registers in the same cycle both take effect.
REQ-026 Set and clear of the same register in one cycle cannot occur (REQ-021); if it does, set wins.
REQ-027 busy_vec[0] is constant 0.
REQ-028 A write-back to a non-busy register is still performed; the scoreboard stays clear.

Reset
REQ-029 While rst=1 at an edge: busy_vec=0, rf_we=0, rf_rd=0, rf_wd=0, RR pointer selects port 0 next.
REQ-030 Reset mid-operation drops any pending registered write; no rf_we pulse follows reset release.
REQ-031 During rst=1, readys still follow REQ-013..017, but handshakes have no effect.

Verification
REQ-032 Single write: alu_valid=1, alu_rd=5, alu_wd=0xDEADBEEF for 1 cycle -> alu_ready=1 that cycle; next cycle rf_we=1, rf_rd=5, rf_wd=0xDEADBEEF; then rf_we=0.
REQ-033 Contention: both valid for 4 cycles (alu_rd=1, lsu_rd=2) after reset -> grants ALU, LSU, ALU, LSU; rf_rd sequence 1,2,1,2, one cycle later each.
REQ-034 RAW: issue rd=7, then iss_rs1=7 -> iss_stall=1 until the LSU writes x7; stall drops the cycle after the rf_we cycle; busy_vec[7] 1 -> 0.
REQ-035 WAW/x0: issue rd=9 then iss_rd=9 -> stall; issue rd=0 -> no stall, busy_vec unchanged; lsu_rd=0 handshake -> rf_we stays 0.
REQ-036 Reset mid-flight: accept lsu_rd=3 with busy_vec[3]=1, assert rst the next cycle -> rf_we=0, busy_vec=0; after release, both valid -> ALU granted first.
